regfile_wr_arbiter: RTL and testbench

Controller that sits in front of the CPU's register-file bank, an array of ROWS rows of 17-bit storage cells, each row with a one-hot write select and two read selects. It zero-fills every row after reset and arbitrates two write requesters onto the bank's single shared write port. Requester A is the core writeback and B is the load/debug path; they are arbitrated round-robin with a valid/ready handshake. It decodes the two read addresses into row selects and optionally forwards in-flight write data to the read outputs.

---
 rtl/regfile_wr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Front-end controller for a register-file bank of ROWS rows, each W bits wide.
// After reset it zero-fills every row, one row per clock (CLEAR). It then
// arbitrates two write requesters (A = core writeback, B = load/debug) onto the
// bank's single write port, round-robin (RUN). Read addresses are decoded into
// one-hot row selects.
//
// Optional feature, enabled by defining the macro REGFILE_BYPASS_EN:
//   a read of the row that the bank is writing this cycle returns the new data
//   (wd) instead of the bank's stale read data.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_a_valid/addr/data     requester A write request
//   o_a_ready               A is accepted on this edge if i_a_valid
//   i_b_valid/addr/data     requester B write request
//   o_b_ready               B is accepted on this edge if i_b_valid
//   i_ra1, i_ra2            read addresses
//   o_ws, o_wd              registered one-hot write select / write data
//   o_rs1, o_rs2            combinational one-hot read selects
//   i_bank_rd1, i_bank_rd2  read data returned by the bank
//   o_rd1, o_rd2            read data to the datapath
//   o_busy                  high while the clear sequence runs
//   o_dbg_state             FSM state (0 = CLEAR, 1 = RUN)
//   o_dbg_prio              priority pointer (0 = A, 1 = B)
//
// Handshake: a write transfers on a rising edge where valid && ready are both
// high. Ready is a function of the FSM state, the priority pointer and the
// OTHER requester's valid only, never of the requester's own valid. At most one
// requester is ready-and-valid on any edge. Addresses >= ROWS still complete the
// handshake, but the write is dropped (no row selected).
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
   parameter int ROWS = 8,
   parameter int AW   = 3,
   parameter int W    = 17
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_a_valid,
   input  logic [AW-1:0]   i_a_addr,
   input  logic [W-1:0]    i_a_data,
   output logic            o_a_ready,
   input  logic            i_b_valid,
   input  logic [AW-1:0]   i_b_addr,
   input  logic [W-1:0]    i_b_data,
   output logic            o_b_ready,
   input  logic [AW-1:0]   i_ra1,
   input  logic [AW-1:0]   i_ra2,
   output logic [ROWS-1:0] o_ws,
   output logic [W-1:0]    o_wd,
   output logic [ROWS-1:0] o_rs1,
   output logic [ROWS-1:0] o_rs2,
   input  logic [W-1:0]    i_bank_rd1,
   input  logic [W-1:0]    i_bank_rd2,
   output logic [W-1:0]    o_rd1,
   output logic [W-1:0]    o_rd2,
   output logic            o_busy,
   output logic            o_dbg_state,
   output logic            o_dbg_prio
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam logic PRIO_A = 1'b0;
   localparam logic PRIO_B = 1'b1;

   state_t          r_state;
   logic [AW-1:0]   r_cnt;
   logic            r_prio;
   logic [ROWS-1:0] r_ws;
   logic [W-1:0]    r_wd;

   state_t          w_state_nxt;
   logic [AW-1:0]   w_cnt_nxt;
   logic            w_prio_nxt;
   logic [ROWS-1:0] w_ws_nxt;
   logic [W-1:0]    w_wd_nxt;

   logic            w_run;
   logic            w_a_ready;
   logic            w_b_ready;
   logic            w_a_acc;
   logic            w_b_acc;
   logic [ROWS-1:0] w_rs1;
   logic [ROWS-1:0] w_rs2;

   // Decode an address into a one-hot row select; out-of-range addresses
   // produce an all-zero select.
   function automatic logic [ROWS-1:0] f_onehot(input logic [AW-1:0] addr);
      logic [ROWS-1:0] v;
      v = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (addr == AW'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   assign w_run     = (r_state == ST_RUN);
   // The pointer only matters when both requesters want the port.
   assign w_a_ready = w_run && (!i_b_valid || (r_prio == PRIO_A));
   assign w_b_ready = w_run && (!i_a_valid || (r_prio == PRIO_B));
   assign w_a_acc   = i_a_valid && w_a_ready;
   assign w_b_acc   = i_b_valid && w_b_ready;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
         r_prio  <= PRIO_A;
         r_ws    <= '0;
         r_wd    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_prio  <= w_prio_nxt;
         r_ws    <= w_ws_nxt;
         r_wd    <= w_wd_nxt;
      end
   end

   // Next-state and write-port logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_prio_nxt  = r_prio;
      w_ws_nxt    = '0;
      w_wd_nxt    = r_wd;
      case (r_state)
         ST_CLEAR: begin
            w_ws_nxt = f_onehot(r_cnt);
            w_wd_nxt = '0;
            if (r_cnt == AW'(ROWS - 1)) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + AW'(1);
            end
         end
         ST_RUN: begin
            // On contention the winner is the pointed-to requester, and the
            // pointer moves to the loser.
            if (i_a_valid && i_b_valid) w_prio_nxt = ~r_prio;
            if (w_a_acc) begin
               w_ws_nxt = f_onehot(i_a_addr);
               w_wd_nxt = i_a_data;
            end else if (w_b_acc) begin
               w_ws_nxt = f_onehot(i_b_addr);
               w_wd_nxt = i_b_data;
            end
         end
         default: begin
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_rs1 = f_onehot(i_ra1);
   assign w_rs2 = f_onehot(i_ra2);

`ifdef REGFILE_BYPASS_EN
   logic w_hit1;
   logic w_hit2;
   // The bank has not captured wd yet during the ws pulse, so forward it.
   assign w_hit1 = (r_ws != '0) && (w_rs1 == r_ws);
   assign w_hit2 = (r_ws != '0) && (w_rs2 == r_ws);
   assign o_rd1  = w_hit1 ? r_wd : i_bank_rd1;
   assign o_rd2  = w_hit2 ? r_wd : i_bank_rd2;
`else
   assign o_rd1  = i_bank_rd1;
   assign o_rd2  = i_bank_rd2;
`endif

   assign o_a_ready   = w_a_ready;
   assign o_b_ready   = w_b_ready;
   assign o_ws        = r_ws;
   assign o_wd        = r_wd;
   assign o_rs1       = w_rs1;
   assign o_rs2       = w_rs2;
   assign o_busy      = (r_state == ST_CLEAR);
   assign o_dbg_state = r_state;
   assign o_dbg_prio  = r_prio;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Bench for regfile_wr_arbiter. Main instance uses ROWS=8; a second instance
// with ROWS=6 covers out-of-range addresses. Each instance drives a small bank
// model that captures wd into the selected row on the edge after ws shows it.
// The reference model tracks the clear sequence, the round-robin grant and a
// golden copy of the register contents.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

   localparam int AW = 3;
   localparam int W  = 17;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // shared stimulus
   logic          a_valid = 1'b0, b_valid = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0, ra1 = '0, ra2 = '0;
   logic [W-1:0]  a_data = '0, b_data = '0;

   // ROWS=8 instance
   logic          a_ready, b_ready, busy, dbg_state, dbg_prio;
   logic [7:0]    ws, rs1, rs2;
   logic [W-1:0]  wd, rd1, rd2, bank_rd1, bank_rd2;

   // ROWS=6 instance
   logic          a_ready_6, b_ready_6, busy_6, dbg_state_6, dbg_prio_6;
   logic [5:0]    ws_6, rs1_6, rs2_6;
   logic [W-1:0]  wd_6, rd1_6, rd2_6, bank_rd1_6, bank_rd2_6;

   regfile_wr_arbiter #(.ROWS(8), .AW(AW), .W(W)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_ready(a_ready),
      .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(b_ready),
      .i_ra1(ra1), .i_ra2(ra2), .o_ws(ws), .o_wd(wd), .o_rs1(rs1), .o_rs2(rs2),
      .i_bank_rd1(bank_rd1), .i_bank_rd2(bank_rd2), .o_rd1(rd1), .o_rd2(rd2),
      .o_busy(busy), .o_dbg_state(dbg_state), .o_dbg_prio(dbg_prio)
   );

   regfile_wr_arbiter #(.ROWS(6), .AW(AW), .W(W)) dut6 (
      .i_clk(clk), .i_rst(rst),
      .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_ready(a_ready_6),
      .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(b_ready_6),
      .i_ra1(ra1), .i_ra2(ra2), .o_ws(ws_6), .o_wd(wd_6), .o_rs1(rs1_6), .o_rs2(rs2_6),
      .i_bank_rd1(bank_rd1_6), .i_bank_rd2(bank_rd2_6), .o_rd1(rd1_6), .o_rd2(rd2_6),
      .o_busy(busy_6), .o_dbg_state(dbg_state_6), .o_dbg_prio(dbg_prio_6)
   );

   // bank models
   logic [W-1:0] bank_mem  [8] = '{default: 17'h15555};
   logic [W-1:0] bank_mem6 [6] = '{default: 17'h0AAAA};

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) if (ws[i]) bank_mem[i] <= wd;
   end
   always @(posedge clk) begin
      for (int i = 0; i < 6; i++) if (ws_6[i]) bank_mem6[i] <= wd_6;
   end
   always_comb begin
      bank_rd1 = '0;
      bank_rd2 = '0;
      for (int i = 0; i < 8; i++) begin
         if (rs1[i]) bank_rd1 = bank_rd1 | bank_mem[i];
         if (rs2[i]) bank_rd2 = bank_rd2 | bank_mem[i];
      end
   end
   always_comb begin
      bank_rd1_6 = '0;
      bank_rd2_6 = '0;
      for (int i = 0; i < 6; i++) begin
         if (rs1_6[i]) bank_rd1_6 = bank_rd1_6 | bank_mem6[i];
         if (rs2_6[i]) bank_rd2_6 = bank_rd2_6 | bank_mem6[i];
      end
   end

   // reference model (ROWS=8 instance)
   int           m_clear_left = 8;
   logic         m_prio = 1'b0;      // 0 = A next on contention, 1 = B
   logic [7:0]   m_ws = '0;
   logic [W-1:0] m_wd = '0;
   logic [W-1:0] gold [8] = '{default: 17'h15555};

   // scoreboard: expected {ws, wd} of each accepted write, in order
   logic [8+W-1:0] exp_q[$];

   int checks = 0;
   int errors = 0;

   function automatic logic [7:0] oh8(input int a);
      if (a >= 0 && a < 8) return 8'd1 << a;
      return 8'h00;
   endfunction

   function automatic logic exp_a_ready();
      return (m_clear_left == 0) && (!b_valid || !m_prio);
   endfunction

   function automatic logic exp_b_ready();
      return (m_clear_left == 0) && (!a_valid || m_prio);
   endfunction

   function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] ra);
`ifdef REGFILE_BYPASS_EN
      if (m_ws != 8'h00 && m_ws == oh8(int'(ra))) return m_wd;
`endif
      return gold[ra];
   endfunction

   // Advance one clock edge; the model updates from the inputs present before it.
   task automatic tick();
      logic [7:0]   nws;
      logic [W-1:0] nwd;
      logic         g_a, g_b;
      nws = '0;
      nwd = m_wd;
      g_a = 1'b0;
      g_b = 1'b0;
      for (int i = 0; i < 8; i++) if (m_ws[i]) gold[i] = m_wd;
      if (m_clear_left > 0) begin
         nws = oh8(8 - m_clear_left);
         nwd = '0;
         m_clear_left--;
      end else begin
         if (a_valid && b_valid) begin
            g_a    = !m_prio;
            g_b    = m_prio;
            m_prio = !m_prio;
         end else begin
            g_a = a_valid;
            g_b = b_valid;
         end
         if (g_a) begin
            nws = oh8(int'(a_addr));
            nwd = a_data;
         end else if (g_b) begin
            nws = oh8(int'(b_addr));
            nwd = b_data;
         end
         if (g_a || g_b) exp_q.push_back({nws, nwd});
      end
      @(posedge clk);
      m_ws = nws;
      m_wd = nwd;
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_clear_left = 8;
      m_prio       = 1'b0;
      m_ws         = '0;
      m_wd         = '0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      a_valid = 1'b1;
      b_valid = 1'b1;
      ra1     = 3'd4;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (ws !== 8'h00) begin errors++; $display("FAIL reset_ws: got %h exp 00", ws); end
      checks++; if (wd !== 17'h0) begin errors++; $display("FAIL reset_wd: got %h exp 0", wd); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b exp 1", busy); end
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got a=%b b=%b exp 0 0", a_ready, b_ready);
      end
      checks++; if (dbg_prio !== 1'b0) begin errors++; $display("FAIL reset_prio: got %b exp 0", dbg_prio); end
      checks++; if (rs1 !== 8'h10) begin errors++; $display("FAIL reset_rs1: got %h exp 10", rs1); end
   endtask

   task automatic test_clear_seq();
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         #1;
         checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++; $display("FAIL clear_ready e%0d: got a=%b b=%b exp 0 0", e, a_ready, b_ready);
         end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy e%0d: got %b exp 1", e, busy); end
         tick();
         checks++; if (ws !== 8'(1 << (e - 1)) || wd !== 17'h0) begin
            errors++; $display("FAIL clear_ws e%0d: got ws=%h wd=%h exp ws=%h wd=0", e, ws, wd, 8'(1 << (e - 1)));
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_done_busy: got %b exp 0", busy); end
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic test_single_a();
      a_valid = 1'b1; a_addr = 3'd5; a_data = 17'h1ABCD; b_valid = 1'b0;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready: got %b exp 1", a_ready); end
      tick();
      checks++; if (ws !== 8'h20 || wd !== 17'h1ABCD) begin
         errors++; $display("FAIL single_a_write: got ws=%h wd=%h exp ws=20 wd=1abcd", ws, wd);
      end
      checks++; if (dbg_prio !== 1'b0) begin errors++; $display("FAIL single_a_prio: got %b exp 0", dbg_prio); end
      a_valid = 1'b0;
      tick();
      checks++; if (ws !== 8'h00 || wd !== 17'h1ABCD) begin
         errors++; $display("FAIL single_a_idle: got ws=%h wd=%h exp ws=00 wd=1abcd", ws, wd);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]   e_ws;
      logic [W-1:0] e_wd;
      a_valid = 1'b1;
      b_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_addr = 3'($urandom_range(0, 7));
         b_addr = a_addr + 3'($urandom_range(1, 7));
         a_data = 17'($urandom);
         b_data = 17'($urandom);
         #1;
         checks++; if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
            errors++; $display("FAIL b2b_ready i%0d: got a=%b b=%b", i, a_ready, b_ready);
         end
         e_ws = (i % 2 == 0) ? oh8(int'(a_addr)) : oh8(int'(b_addr));
         e_wd = (i % 2 == 0) ? a_data : b_data;
         tick();
         checks++; if (ws !== e_ws || wd !== e_wd) begin
            errors++; $display("FAIL b2b_write i%0d: got ws=%h wd=%h exp ws=%h wd=%h", i, ws, wd, e_ws, e_wd);
         end
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      checks++; if (ws !== 8'h00) begin errors++; $display("FAIL b2b_end: got ws=%h exp 00", ws); end
   endtask

   task automatic test_bypass();
      logic [W-1:0] d, e_rd;
      d = 17'($urandom);
      a_valid = 1'b1; a_addr = 3'd7; a_data = d;
      tick();
      a_valid = 1'b0;
      ra1 = 3'd7;
      #1;
`ifdef REGFILE_BYPASS_EN
      e_rd = d;
`else
      e_rd = gold[7];
`endif
      checks++; if (rs1 !== 8'h80) begin errors++; $display("FAIL bypass_rs1: got %h exp 80", rs1); end
      checks++; if (rd1 !== e_rd) begin errors++; $display("FAIL bypass_rd1_pulse: got %h exp %h", rd1, e_rd); end
      tick();
      #1;
      checks++; if (rd1 !== d) begin errors++; $display("FAIL bypass_rd1_after: got %h exp %h", rd1, d); end
   endtask

   task automatic test_reset_mid();
      a_valid = 1'b1; a_addr = 3'd1; b_valid = 1'b1; b_addr = 3'd2;
      tick();
      b_valid = 1'b0; a_addr = 3'd3;
      tick();
      checks++; if (ws !== 8'h08 || dbg_prio !== 1'b1) begin
         errors++; $display("FAIL rmid_pre: got ws=%h prio=%b exp ws=08 prio=1", ws, dbg_prio);
      end
      a_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      checks++; if (ws !== 8'h00 || busy !== 1'b1) begin
         errors++; $display("FAIL rmid_async: got ws=%h busy=%b exp ws=00 busy=1", ws, busy);
      end
      checks++; if (dbg_prio !== 1'b0) begin errors++; $display("FAIL rmid_prio: got %b exp 0", dbg_prio); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++; if (ws !== 8'(1 << (e - 1)) || wd !== 17'h0) begin
            errors++; $display("FAIL rmid_clear e%0d: got ws=%h wd=%h exp ws=%h", e, ws, wd, 8'(1 << (e - 1)));
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b exp 0", busy); end
   endtask

   task automatic test_rows6();
      a_valid = 1'b0; b_valid = 1'b1; b_addr = 3'd7; b_data = 17'($urandom);
      ra1 = 3'd6; ra2 = 3'd6;
      #1;
      checks++; if (b_ready_6 !== 1'b1) begin errors++; $display("FAIL r6_ready: got %b exp 1", b_ready_6); end
      checks++; if (rs2_6 !== 6'h00 || rd2_6 !== 17'h0) begin
         errors++; $display("FAIL r6_read2: got rs2=%h rd2=%h exp 00 0", rs2_6, rd2_6);
      end
      checks++; if (rs1_6 !== 6'h00 || rd1_6 !== 17'h0) begin
         errors++; $display("FAIL r6_read1: got rs1=%h rd1=%h exp 00 0", rs1_6, rd1_6);
      end
      tick();
      checks++; if (ws_6 !== 6'h00) begin errors++; $display("FAIL r6_ws: got %h exp 00", ws_6); end
      b_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [8+W-1:0] e;
      exp_q.delete();
      for (int n = 0; n < 400; n++) begin
         a_valid = 1'($urandom_range(0, 1));
         b_valid = 1'($urandom_range(0, 1));
         a_addr  = 3'($urandom_range(0, 7));
         b_addr  = 3'($urandom_range(0, 7));
         a_data  = 17'($urandom);
         b_data  = 17'($urandom);
         ra1     = 3'($urandom_range(0, 7));
         ra2     = 3'($urandom_range(0, 7));
         #1;
         checks++; if (a_ready !== exp_a_ready() || b_ready !== exp_b_ready()) begin
            errors++; $display("FAIL rnd_ready n%0d: got a=%b b=%b exp a=%b b=%b", n, a_ready, b_ready, exp_a_ready(), exp_b_ready());
         end
         checks++; if (rs1 !== oh8(int'(ra1)) || rs2 !== oh8(int'(ra2))) begin
            errors++; $display("FAIL rnd_rs n%0d: got %h %h exp %h %h", n, rs1, rs2, oh8(int'(ra1)), oh8(int'(ra2)));
         end
         checks++; if (rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2)) begin
            errors++; $display("FAIL rnd_rd n%0d: got %h %h exp %h %h", n, rd1, rd2, exp_rd(ra1), exp_rd(ra2));
         end
         tick();
         checks++; if (ws !== m_ws || wd !== m_wd || dbg_prio !== m_prio) begin
            errors++; $display("FAIL rnd_reg n%0d: got ws=%h wd=%h prio=%b exp ws=%h wd=%h prio=%b", n, ws, wd, dbg_prio, m_ws, m_wd, m_prio);
         end
         if (ws !== 8'h00) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rnd_sb n%0d: got write ws=%h with empty queue", n, ws);
            end else begin
               e = exp_q.pop_front();
               if ({ws, wd} !== e) begin
                  errors++; $display("FAIL rnd_sb n%0d: got %h exp %h", n, {ws, wd}, e);
               end
            end
         end
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_sb_left: got %0d exp 0", exp_q.size()); end
      for (int r = 0; r < 8; r++) begin
         ra1 = 3'(r);
         #1;
         checks++; if (rd1 !== gold[r]) begin errors++; $display("FAIL final_mem r%0d: got %h exp %h", r, rd1, gold[r]); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clear_seq();
      test_single_a();
      test_back_to_back();
      test_bypass();
      test_reset_mid();
      test_rows6();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
